// File: rtl/xbox_csr_pkg.sv
// Shared types and helpers for the XBOX accelerator APB CSR bank.
package xbox_csr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } apb_state_e;

    localparam int NUM_REGS_DEF = 32;
    localparam int DONE_REG_DEF = 1;
    // The bank never exceeds 32 registers, so five index bits always suffice.
    localparam int REG_IDX_W    = 5;

    function automatic logic csr_addr_err(input logic [31:0] byte_addr,
                                          input int unsigned num_regs);
        return (byte_addr[1:0] != 2'b00) || ((byte_addr >> 2) >= num_regs);
    endfunction

endpackage

// File: rtl/xbox_csr_capture.sv
// Per-register accelerator status capture and SW readback select.
// A capture takes priority over the ownership clear from a same-edge SW write.
module xbox_csr_capture (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_clr_i,
    input  logic        cap_vld_i,
    input  logic [31:0] cap_dat_i,
    input  logic [31:0] host_reg_i,
    output logic [31:0] rd_dat_o
);

    logic [31:0] shadow_q;
    logic        owned_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= '0;
            owned_q  <= 1'b0;
        end else if (cap_vld_i) begin
            shadow_q <= cap_dat_i;
            owned_q  <= 1'b1;
        end else if (wr_clr_i) begin
            owned_q  <= 1'b0;
        end
    end

    assign rd_dat_o = owned_q ? shadow_q : host_reg_i;

endmodule

// File: rtl/xbox_xlr_csr_apb.sv
// APB responder for the XBOX accelerator CSR bank: one wait state per access,
// registered response, per-register write pulses and a sticky completion IRQ.
module xbox_xlr_csr_apb
    import xbox_csr_pkg::*;
#(
    parameter int NUM_REGS   = NUM_REGS_DEF,
    parameter int APB_ADDR_W = 12,
    parameter int DONE_REG   = DONE_REG_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     psel,
    input  logic                     penable,
    input  logic                     pwrite,
    input  logic [APB_ADDR_W-1:0]    paddr,
    input  logic [31:0]              pwdata,
    output logic [31:0]              prdata,
    output logic                     pready,
    output logic                     pslverr,
    output logic [NUM_REGS*32-1:0]   host_regs,
    output logic [NUM_REGS-1:0]      host_regs_valid_pulse,
    input  logic [NUM_REGS*32-1:0]   host_regs_data_out,
    input  logic [NUM_REGS-1:0]      host_regs_valid_out,
    output logic                     xlr_irq
);

    apb_state_e                  state_q, state_d;
    logic [APB_ADDR_W-1:0]       addr_q;
    logic                        write_q;
    logic [31:0]                 prdata_q;
    logic                        pready_q;
    logic                        pslverr_q;
    logic                        irq_q;
    logic [NUM_REGS-1:0][31:0]   host_regs_q;
    logic [NUM_REGS-1:0]         pulse_q;

    logic                        setup;
    logic                        addr_err;
    logic [REG_IDX_W-1:0]        idx;
    logic                        wr_commit;
    logic [NUM_REGS-1:0]         wr_stb;
    logic [NUM_REGS-1:0][31:0]   rd_word;
    logic [31:0]                 rd_sel;

    // penable without a preceding setup phase is a protocol violation and never starts a transfer.
    assign setup     = (state_q == ST_IDLE) && psel && !penable;
    assign addr_err  = csr_addr_err(32'(addr_q), NUM_REGS);
    assign idx       = addr_q[REG_IDX_W+1:2];
    assign wr_commit = (state_q == ST_RESP) && write_q && !addr_err;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (setup) state_d = ST_WAIT;
            ST_WAIT: state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_stb = '0;
        rd_sel = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx == REG_IDX_W'(i)) begin
                wr_stb[i] = wr_commit;
                rd_sel    = rd_word[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            write_q     <= 1'b0;
            prdata_q    <= '0;
            pready_q    <= 1'b0;
            pslverr_q   <= 1'b0;
            irq_q       <= 1'b0;
            host_regs_q <= '0;
            pulse_q     <= '0;
        end else begin
            state_q <= state_d;
            pulse_q <= wr_stb;
            if (setup) begin
                addr_q  <= paddr;
                write_q <= pwrite;
            end
            if (state_q == ST_WAIT) begin
                pready_q  <= 1'b1;
                pslverr_q <= addr_err;
                prdata_q  <= (addr_err || write_q) ? 32'd0 : rd_sel;
            end else if (state_q == ST_RESP) begin
                pready_q  <= 1'b0;
                pslverr_q <= 1'b0;
            end
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_stb[i]) host_regs_q[i] <= pwdata;
            end
            if (host_regs_valid_out[DONE_REG]) begin
                irq_q <= 1'b1;
            end else if (wr_stb[DONE_REG]) begin
                irq_q <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_cap
        xbox_csr_capture u_cap (
            .clk        (clk),
            .rst        (rst),
            .wr_clr_i   (wr_stb[g]),
            .cap_vld_i  (host_regs_valid_out[g]),
            .cap_dat_i  (host_regs_data_out[g*32 +: 32]),
            .host_reg_i (host_regs_q[g]),
            .rd_dat_o   (rd_word[g])
        );
    end

    assign prdata                = prdata_q;
    assign pready                = pready_q;
    assign pslverr               = pslverr_q;
    assign xlr_irq               = irq_q;
    assign host_regs             = host_regs_q;
    assign host_regs_valid_pulse = pulse_q;

endmodule

// File: tb/tb_xbox_xlr_csr_apb.sv
// Bench for xbox_xlr_csr_apb: directed vector table, hand sequences, random traffic vs model.
module tb_xbox_xlr_csr_apb;

    logic          clk = 1'b0;
    logic          rst, psel, penable, pwrite;
    logic [11:0]   paddr;
    logic [31:0]   pwdata, prdata;
    logic          pready, pslverr, xlr_irq;
    logic [1023:0] host_regs, host_regs_data_out;
    logic [31:0]   host_regs_valid_pulse, host_regs_valid_out;

    int ntests = 0;
    int nfail  = 0;

    always #5 clk = ~clk;

    xbox_xlr_csr_apb #(.NUM_REGS(32), .APB_ADDR_W(12), .DONE_REG(1)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .psel                  (psel),
        .penable               (penable),
        .pwrite                (pwrite),
        .paddr                 (paddr),
        .pwdata                (pwdata),
        .prdata                (prdata),
        .pready                (pready),
        .pslverr               (pslverr),
        .host_regs             (host_regs),
        .host_regs_valid_pulse (host_regs_valid_pulse),
        .host_regs_data_out    (host_regs_data_out),
        .host_regs_valid_out   (host_regs_valid_out),
        .xlr_irq               (xlr_irq)
    );

    typedef struct {
        logic        wr;
        logic [11:0] a;
        logic [31:0] d;
        int          k;        // cycle of transfer carrying a capture (0..2), 3 = none
        int          ci;
        logic [31:0] cd;
        logic [31:0] exp_rd;
        logic        exp_err;
        logic [31:0] exp_pulse;
        logic        exp_irq;
        int          hr_idx;
        logic [31:0] exp_hr;
    } vec_t;

    vec_t tbl[17];

    logic [31:0] m_host[32];
    logic [31:0] m_shadow[32];
    bit          m_owned[32];
    bit          m_irq;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] hreg(input int i);
        return host_regs[i*32 +: 32];
    endfunction

    task automatic do_reset();
        rst = 1'b1; psel = 1'b0; penable = 1'b0; host_regs_valid_out = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Entered and left 1 time unit after a rising edge; returns at T3 of the transfer.
    task automatic xfer(input logic wr, input logic [11:0] a, input logic [31:0] d,
                        input int k, input int ci, input logic [31:0] cd,
                        output logic [31:0] rd, output logic err, output logic ok);
        logic [31:0] oh;
        oh = 32'd1 << ci;
        if (k < 3) host_regs_data_out[ci*32 +: 32] = cd;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        host_regs_valid_out = (k == 0) ? oh : '0;
        @(posedge clk); #1;
        penable = 1'b1;
        host_regs_valid_out = (k == 1) ? oh : '0;
        ok = !pready;
        @(posedge clk); #1;
        host_regs_valid_out = (k == 2) ? oh : '0;
        rd = prdata; err = pslverr; ok = ok && pready;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; host_regs_valid_out = '0;
    endtask

    task automatic m_cap(input int ci, input logic [31:0] cd);
        m_shadow[ci] = cd;
        m_owned[ci]  = 1'b1;
        if (ci == 1) m_irq = 1'b1;
    endtask

    initial begin
        logic [31:0] rd, exp_rd, exp_pulse;
        logic        err, ok, exp_err;
        logic [11:0] a;
        logic [31:0] d, cd;
        int          k, ci, idx;
        logic        wr;

        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        host_regs_data_out = '0; host_regs_valid_out = '0;
        do_reset();

        chk("rst_prdata",  prdata, 32'd0);
        chk("rst_pready",  {31'd0, pready}, 32'd0);
        chk("rst_pslverr", {31'd0, pslverr}, 32'd0);
        chk("rst_irq",     {31'd0, xlr_irq}, 32'd0);
        chk("rst_pulse",   host_regs_valid_pulse, 32'd0);
        chk("rst_hregs",   {31'd0, |host_regs}, 32'd0);

        //          wr    addr     wdata         k ci cd          exp_rd      err   pulse       irq   hr exp_hr
        tbl[0]  = '{1'b0, 12'h008, 32'h0,        3, 0, 32'h0,     32'h0,      1'b0, 32'h0,      1'b0, 2, 32'h0};
        tbl[1]  = '{1'b1, 12'h00C, 32'hA,        3, 0, 32'h0,     32'h0,      1'b0, 32'h8,      1'b0, 3, 32'hA};
        tbl[2]  = '{1'b0, 12'h00C, 32'h0,        3, 0, 32'h0,     32'hA,      1'b0, 32'h0,      1'b0, 3, 32'hA};
        tbl[3]  = '{1'b0, 12'h004, 32'h0,        0, 1, 32'h1,     32'h1,      1'b0, 32'h0,      1'b1, 1, 32'h0};
        tbl[4]  = '{1'b1, 12'h004, 32'h0,        3, 0, 32'h0,     32'h0,      1'b0, 32'h2,      1'b0, 1, 32'h0};
        tbl[5]  = '{1'b0, 12'h004, 32'h0,        3, 0, 32'h0,     32'h0,      1'b0, 32'h0,      1'b0, 1, 32'h0};
        tbl[6]  = '{1'b1, 12'h008, 32'h5,        2, 2, 32'h77,    32'h0,      1'b0, 32'h4,      1'b0, 2, 32'h5};
        tbl[7]  = '{1'b0, 12'h008, 32'h0,        3, 0, 32'h0,     32'h77,     1'b0, 32'h0,      1'b0, 2, 32'h5};
        tbl[8]  = '{1'b1, 12'h000, 32'hBEEF,     3, 0, 32'h0,     32'h0,      1'b0, 32'h1,      1'b0, 0, 32'hBEEF};
        tbl[9]  = '{1'b1, 12'h082, 32'hDEAD,     3, 0, 32'h0,     32'h0,      1'b1, 32'h0,      1'b0, 0, 32'hBEEF};
        tbl[10] = '{1'b0, 12'h080, 32'h0,        3, 0, 32'h0,     32'h0,      1'b1, 32'h0,      1'b0, 0, 32'hBEEF};
        tbl[11] = '{1'b1, 12'h00E, 32'h7,        3, 0, 32'h0,     32'h0,      1'b1, 32'h0,      1'b0, 3, 32'hA};
        tbl[12] = '{1'b0, 12'h07C, 32'h0,        3, 0, 32'h0,     32'h0,      1'b0, 32'h0,      1'b0, 31, 32'h0};
        tbl[13] = '{1'b1, 12'h004, 32'h9,        2, 1, 32'h33,    32'h0,      1'b0, 32'h2,      1'b1, 1, 32'h9};
        tbl[14] = '{1'b0, 12'h004, 32'h0,        3, 0, 32'h0,     32'h33,     1'b0, 32'h0,      1'b1, 1, 32'h9};
        tbl[15] = '{1'b0, 12'h010, 32'h0,        1, 4, 32'h44,    32'h0,      1'b0, 32'h0,      1'b1, 4, 32'h0};
        tbl[16] = '{1'b0, 12'h010, 32'h0,        3, 0, 32'h0,     32'h44,     1'b0, 32'h0,      1'b1, 4, 32'h0};

        for (int r = 0; r < 17; r++) begin
            xfer(tbl[r].wr, tbl[r].a, tbl[r].d, tbl[r].k, tbl[r].ci, tbl[r].cd, rd, err, ok);
            chk($sformatf("vec%0d_handshake", r), {31'd0, ok}, 32'd1);
            chk($sformatf("vec%0d_pslverr", r), {31'd0, err}, {31'd0, tbl[r].exp_err});
            if (!tbl[r].wr) chk($sformatf("vec%0d_prdata", r), rd, tbl[r].exp_rd);
            chk($sformatf("vec%0d_pulse", r), host_regs_valid_pulse, tbl[r].exp_pulse);
            chk($sformatf("vec%0d_irq", r), {31'd0, xlr_irq}, {31'd0, tbl[r].exp_irq});
            chk($sformatf("vec%0d_hreg", r), hreg(tbl[r].hr_idx), tbl[r].exp_hr);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_pulse_end", r), host_regs_valid_pulse, 32'd0);
        end

        // Standalone capture on the done register: IRQ rises the cycle after the pulse.
        xfer(1'b1, 12'h004, 32'h0, 3, 0, 32'h0, rd, err, ok);
        chk("irq_cleared", {31'd0, xlr_irq}, 32'd0);
        host_regs_data_out[32 +: 32] = 32'h1;
        host_regs_valid_out = 32'h2;
        chk("irq_before_edge", {31'd0, xlr_irq}, 32'd0);
        @(posedge clk); #1;
        host_regs_valid_out = '0;
        chk("irq_after_capture", {31'd0, xlr_irq}, 32'd1);

        // Random back-to-back traffic against the model.
        do_reset();
        for (int i = 0; i < 32; i++) begin
            m_host[i] = '0; m_shadow[i] = '0; m_owned[i] = 1'b0;
        end
        m_irq = 1'b0;
        for (int n = 0; n < 80; n++) begin
            wr = 1'($urandom_range(0, 1));
            a  = 12'($urandom_range(0, 33)) << 2;
            if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
            d  = $urandom;
            k  = $urandom_range(0, 3);
            ci = $urandom_range(0, 3);
            cd = $urandom;
            idx = int'(a >> 2);
            exp_err = (a[1:0] != 2'b00) || (idx >= 32);
            exp_rd = '0;
            exp_pulse = '0;
            if (!wr) begin
                if (k == 0) m_cap(ci, cd);
                if (!exp_err) exp_rd = m_owned[idx] ? m_shadow[idx] : m_host[idx];
                if (k == 1 || k == 2) m_cap(ci, cd);
            end else begin
                if (k < 2) m_cap(ci, cd);
                if (!exp_err) begin
                    m_host[idx] = d;
                    m_owned[idx] = 1'b0;
                    if (idx == 1) m_irq = 1'b0;
                    exp_pulse = 32'd1 << idx;
                end
                if (k == 2) m_cap(ci, cd);
            end
            xfer(wr, a, d, k, ci, cd, rd, err, ok);
            chk($sformatf("rnd%0d_handshake", n), {31'd0, ok}, 32'd1);
            chk($sformatf("rnd%0d_pslverr", n), {31'd0, err}, {31'd0, exp_err});
            if (!wr) chk($sformatf("rnd%0d_prdata", n), rd, exp_rd);
            chk($sformatf("rnd%0d_pulse", n), host_regs_valid_pulse, exp_pulse);
            chk($sformatf("rnd%0d_irq", n), {31'd0, xlr_irq}, {31'd0, m_irq});
        end
        for (int i = 0; i < 32; i++) chk($sformatf("rnd_final_hreg%0d", i), hreg(i), m_host[i]);

        // Reset during the wait state of a write: nothing commits, then a fresh write works.
        do_reset();
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h010; pwdata = 32'h55;
        @(posedge clk); #1;
        penable = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_pready", {31'd0, pready}, 32'd0);
        rst = 1'b0; psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        chk("midrst_pready_after", {31'd0, pready}, 32'd0);
        chk("midrst_hreg4", hreg(4), 32'd0);
        chk("midrst_pulse", host_regs_valid_pulse, 32'd0);
        xfer(1'b1, 12'h010, 32'h55, 3, 0, 32'h0, rd, err, ok);
        chk("restart_handshake", {31'd0, ok}, 32'd1);
        chk("restart_hreg4", hreg(4), 32'h55);
        chk("restart_pulse", host_regs_valid_pulse, 32'h10);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
